// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorting network over DATA_N unsigned DATA_W-bit words.
// Define ODD_EVEN_SORTER_DESCEND_EN to sort in descending order instead of ascending.
module odd_even_sorter #(
   parameter int DATA_W  = 8,
   parameter int DATA_N  = 7,
   parameter int PIPE_EN = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_N-1:0][DATA_W-1:0]  data_in,
   output logic [DATA_N-1:0][DATA_W-1:0]  data_o
);

   localparam int unsigned N = DATA_N;

   typedef logic [DATA_N-1:0][DATA_W-1:0] vec_t;

   function automatic logic out_of_order(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef ODD_EVEN_SORTER_DESCEND_EN
      return a < b;
`else
      return a > b;
`endif
   endfunction

   // Pairs within one stage are disjoint, so every swap reads the stage input.
   function automatic vec_t cx_stage(input vec_t v, input int unsigned s);
      vec_t r;
      r = v;
      for (int unsigned j = 0; j + 1 < N; j++) begin
         if (((j % 2) == (s % 2)) && out_of_order(v[j], v[j+1])) begin
            r[j]   = v[j+1];
            r[j+1] = v[j];
         end
      end
      return r;
   endfunction

   if (PIPE_EN != 0) begin : g_pipe
      vec_t pipe_d [N];
      vec_t pipe_q [N];

      always_comb begin
         pipe_d[0] = cx_stage(data_in, 0);
         for (int unsigned s = 1; s < N; s++) begin
            pipe_d[s] = cx_stage(pipe_q[s-1], s);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned s = 0; s < N; s++) begin
               pipe_q[s] <= '0;
            end
         end else begin
            for (int unsigned s = 0; s < N; s++) begin
               pipe_q[s] <= pipe_d[s];
            end
         end
      end

      assign data_o = pipe_q[N-1];
   end else begin : g_comb
      vec_t sort_d;
      vec_t out_q;

      always_comb begin
         vec_t v;
         v = data_in;
         for (int unsigned s = 0; s < N; s++) begin
            v = cx_stage(v, s);
         end
         sort_d = v;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q <= '0;
         end else begin
            out_q <= sort_d;
         end
      end

      assign data_o = out_q;
   end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Self-checking bench: pipelined and combinational sorter instances against a reference sort.
// Expected ordering follows ODD_EVEN_SORTER_DESCEND_EN when it is defined.
module tb_odd_even_sorter;

   localparam int N = 7;
   localparam int W = 8;

   typedef logic [N-1:0][W-1:0] vec_t;
   typedef int unsigned arr_t [N];

   logic clk;
   logic rst_n;
   vec_t data_in;
   vec_t data_o_p;
   vec_t data_o_c;

   int unsigned assert_cnt = 0;
   int unsigned fail_cnt   = 0;

   vec_t hist [$];

   odd_even_sorter #(.DATA_W(W), .DATA_N(N), .PIPE_EN(1)) dut_p (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .data_o  (data_o_p)
   );

   odd_even_sorter #(.DATA_W(W), .DATA_N(N), .PIPE_EN(0)) dut_c (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .data_o  (data_o_c)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Reference: plain selection sort of the elements.
   function automatic vec_t ref_sort(input vec_t v);
      int unsigned a [N];
      int unsigned t;
      vec_t r;
      for (int i = 0; i < N; i++) a[i] = int'(v[i]);
      for (int i = 0; i < N; i++) begin
         for (int k = i + 1; k < N; k++) begin
            if (a[k] < a[i]) begin
               t = a[i]; a[i] = a[k]; a[k] = t;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
`ifdef ODD_EVEN_SORTER_DESCEND_EN
         r[i] = W'(a[N-1-i]);
`else
         r[i] = W'(a[i]);
`endif
      end
      return r;
   endfunction

   function automatic vec_t mk_vec(input arr_t e);
      vec_t r;
      for (int i = 0; i < N; i++) r[i] = W'(e[i]);
      return r;
   endfunction

   // Hand-written ascending answer, flipped for the descending build.
   function automatic vec_t mk_exp(input arr_t asc);
      vec_t r;
      for (int i = 0; i < N; i++) begin
`ifdef ODD_EVEN_SORTER_DESCEND_EN
         r[i] = W'(asc[N-1-i]);
`else
         r[i] = W'(asc[i]);
`endif
      end
      return r;
   endfunction

   function automatic vec_t exp_pipe();
      if (hist.size() < N) return '0;
      return ref_sort(hist[hist.size() - N]);
   endfunction

   function automatic vec_t exp_comb();
      if (hist.size() == 0) return '0;
      return ref_sort(hist[hist.size() - 1]);
   endfunction

   function automatic vec_t rand_vec(input bit dups);
      vec_t r;
      for (int i = 0; i < N; i++) begin
         r[i] = dups ? W'($urandom_range(0, 3)) : W'($urandom);
      end
      return r;
   endfunction

   task automatic step(input vec_t v);
      data_in = v;
      @(posedge clk);
      #1;
      hist.push_back(v);
      if (hist.size() > N) void'(hist.pop_front());
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      hist.delete();
   endtask

   task automatic test_reset();
      rst_n   = 1;
      data_in = '0;
      #2;
      rst_n = 0;
      #1;
      assert_cnt++;
      if (data_o_p !== '0) begin
         fail_cnt++;
         $display("FAIL reset_pipe: got %h want 0", data_o_p);
      end
      assert_cnt++;
      if (data_o_c !== '0) begin
         fail_cnt++;
         $display("FAIL reset_comb: got %h want 0", data_o_c);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      hist.delete();
   endtask

   task automatic test_basic_sort();
      arr_t src = '{5, 3, 9, 1, 7, 2, 8};
      arr_t asc = '{1, 2, 3, 5, 7, 8, 9};
      vec_t want;
      want = mk_exp(asc);
      do_reset();
      step(mk_vec(src));
      assert_cnt++;
      if (data_o_c !== want) begin
         fail_cnt++;
         $display("FAIL basic_comb: got %h want %h", data_o_c, want);
      end
      for (int k = 1; k < N; k++) begin
         assert_cnt++;
         if (data_o_p !== '0) begin
            fail_cnt++;
            $display("FAIL basic_pipe_early step %0d: got %h want 0", k, data_o_p);
         end
         step('0);
      end
      assert_cnt++;
      if (data_o_p !== want) begin
         fail_cnt++;
         $display("FAIL basic_pipe_latency: got %h want %h", data_o_p, want);
      end
   endtask

   task automatic test_fixed(input string name, input arr_t src, input arr_t asc);
      vec_t want;
      want = mk_exp(asc);
      step(mk_vec(src));
      assert_cnt++;
      if (data_o_c !== want) begin
         fail_cnt++;
         $display("FAIL %s_comb: got %h want %h", name, data_o_c, want);
      end
      for (int k = 1; k < N; k++) step('0);
      assert_cnt++;
      if (data_o_p !== want) begin
         fail_cnt++;
         $display("FAIL %s_pipe: got %h want %h", name, data_o_p, want);
      end
   endtask

   task automatic test_reverse_dups();
      arr_t src = '{255, 200, 200, 100, 50, 0, 0};
      arr_t asc = '{0, 0, 50, 100, 200, 200, 255};
      test_fixed("reverse_dups", src, asc);
   endtask

   task automatic test_all_equal();
      arr_t src = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
      test_fixed("all_equal", src, src);
   endtask

   task automatic test_random_held();
      vec_t v;
      for (int n = 0; n < 8; n++) begin
         v = rand_vec(n[0]);
         for (int c = 0; c < 20; c++) begin
            step(v);
            assert_cnt++;
            if (data_o_p !== exp_pipe()) begin
               fail_cnt++;
               $display("FAIL held_pipe vec %0d clk %0d: got %h want %h", n, c, data_o_p, exp_pipe());
            end
            assert_cnt++;
            if (data_o_c !== exp_comb()) begin
               fail_cnt++;
               $display("FAIL held_comb vec %0d clk %0d: got %h want %h", n, c, data_o_c, exp_comb());
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 20 + N - 1; c++) begin
         step(c < 20 ? rand_vec(c % 3 == 0) : '0);
         assert_cnt++;
         if (data_o_p !== exp_pipe()) begin
            fail_cnt++;
            $display("FAIL b2b_pipe clk %0d: got %h want %h", c, data_o_p, exp_pipe());
         end
         assert_cnt++;
         if (data_o_c !== exp_comb()) begin
            fail_cnt++;
            $display("FAIL b2b_comb clk %0d: got %h want %h", c, data_o_c, exp_comb());
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < N + 2; c++) step(rand_vec(1'b0));
      #2;
      rst_n = 0;
      #1;
      assert_cnt++;
      if (data_o_p !== '0) begin
         fail_cnt++;
         $display("FAIL midreset_pipe_async: got %h want 0", data_o_p);
      end
      assert_cnt++;
      if (data_o_c !== '0) begin
         fail_cnt++;
         $display("FAIL midreset_comb_async: got %h want 0", data_o_c);
      end
      data_in = rand_vec(1'b0);
      @(posedge clk);
      #1;
      assert_cnt++;
      if (data_o_p !== '0) begin
         fail_cnt++;
         $display("FAIL midreset_pipe_held: got %h want 0", data_o_p);
      end
      rst_n = 1;
      hist.delete();
      for (int c = 0; c < 2 * N; c++) begin
         step(rand_vec(c[0]));
         assert_cnt++;
         if (data_o_p !== exp_pipe()) begin
            fail_cnt++;
            $display("FAIL postreset_pipe clk %0d: got %h want %h", c, data_o_p, exp_pipe());
         end
         if (c < N - 1) begin
            assert_cnt++;
            if (data_o_p !== '0) begin
               fail_cnt++;
               $display("FAIL postreset_pipe_zero clk %0d: got %h want 0", c, data_o_p);
            end
         end
         assert_cnt++;
         if (data_o_c !== exp_comb()) begin
            fail_cnt++;
            $display("FAIL postreset_comb clk %0d: got %h want %h", c, data_o_c, exp_comb());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_sort();
      test_reverse_dups();
      test_all_equal();
      test_random_held();
      test_back_to_back();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/odd_even_sorter.md
Name: odd_even_sorter

Overview:
- Parameterised sorting network: sorts DATA_N unsigned words of DATA_W bits using odd-even transposition, with DATA_N compare-exchange stages.
- Used as a datapath block wherever a fixed-size vector must be ordered.
- PIPE_EN selects the implementation:
  - Fully pipelined: one register per stage, one new vector accepted per clock.
  - Combinational network with a single output register.

Parameters:
- DATA_W, 8, width of each element in bits; unsigned; must be at least 1.
- DATA_N, 7, number of elements; must be at least 2; odd and even values both supported.
- PIPE_EN, 1, 1 = register after every stage; 0 = all stages combinational plus one output register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_N*DATA_W  packed array [DATA_N-1:0][DATA_W-1:0]; element i is data_in[i]; sampled every clock, no valid strobe.
- data_o  output  DATA_N*DATA_W  packed array [DATA_N-1:0][DATA_W-1:0]; sorted result, registered.

Behaviour:
- Single clock domain; one clock and one reset.
- Asynchronous, active-low reset: rst_n low immediately clears every pipeline register and data_o to all zeros. Release is synchronous to clk.
- Stages are numbered s = 0..DATA_N-1. Each stage performs these compare-exchanges:
  - Even s: pairs (0,1), (2,3), (4,5), …
  - Odd s: pairs (1,2), (3,4), (5,6), …
  - An element with no partner passes through unchanged.
- Compare-exchange on pair (j, j+1): if elem[j] > elem[j+1], swap them; otherwise pass both unchanged. Equal values are never swapped.
- Comparison is unsigned, full DATA_W width. No element is modified; data_o is a permutation of data_in.
- Final order is ascending: data_o[0] holds the minimum and data_o[DATA_N-1] the maximum.
- Timing with PIPE_EN=1:
  - Stage s output is registered.
  - A vector present on data_in at rising edge t appears sorted on data_o after rising edge t+DATA_N-1, i.e. latency is DATA_N clocks.
  - Throughput is one vector per clock; consecutive inputs never interfere.
- Timing with PIPE_EN=0:
  - All DATA_N stages are combinational; only data_o is registered.
  - Latency is 1 clock: data_in at edge t appears on data_o after edge t.
- Both configurations must produce identical data_o sequences, apart from the latency offset.
- Reset asserted mid-operation: all in-flight vectors are discarded and data_o reads 0.
  - After release, data_o shows all-zero vectors until the first post-reset input has traversed the full latency.
- No X propagation: all registers have a reset value.

Optional Feature:
- Macro: ODD_EVEN_SORTER_DESCEND_EN.
- Defined: every compare-exchange swaps when elem[j] < elem[j+1]. data_o is descending, with data_o[0] the maximum. Latency, reset and stage structure are unchanged.
- Undefined (default): ascending order as specified above.

Test Plan:
- Basic sort, default parameters, PIPE_EN=1: data_in[0..6] = 5,3,9,1,7,2,8 → data_o[0..6] = 1,2,3,5,7,8,9, exactly 7 clocks later; data_o stays 0 before that.
- Same vector with PIPE_EN=0 → data_o = 1,2,3,5,7,8,9 after 1 clock. Both instances driven with identical random vectors every 20 clocks (8 vectors) must match after aligning the latency.
- Reverse order and duplicates:
  - Input 255,200,200,100,50,0,0 → 0,0,50,100,200,200,255.
  - All-equal 0x7F → unchanged output.
- Back-to-back throughput, PIPE_EN=1: a new random vector every clock for 20 clocks → each output is the sorted version of the input exactly 7 clocks earlier; compare against a reference sort.
- Reset mid-stream: assert rst_n=0 while the pipeline is full → data_o reads 0 immediately, without waiting for a clock edge. After release, data_o shows all-zero vectors until the first post-reset vector emerges at full latency.
- Compile with ODD_EVEN_SORTER_DESCEND_EN: input 5,3,9,1,7,2,8 → output 9,8,7,5,3,2,1.
